// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM states, prefix bytes and key-word layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Bytes swallowed after the pause prefix (rest of the pause sequence)
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int unsigned KEY_W           = 11;
    localparam int unsigned KEY_TOGGLE_BIT  = 10;
    localparam int unsigned KEY_PRESSED_BIT = 9;
    localparam int unsigned KEY_EXT_BIT     = 8;
    localparam int unsigned KEY_CODE_MSB    = 7;
    localparam int unsigned KEY_CODE_LSB    = 0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one PS/2 line.
module ps2_line_filter #(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic line_out
);

    localparam int unsigned     CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt_q;

    // Bring the raw asynchronous line into the clk domain; idle level is high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= line_in;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after FILTER_CYCLES consecutive samples disagree with the current one
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_out <= 1'b1;
            cnt_q    <= '0;
        end else if (sync_q2 == line_out) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            line_out <= sync_q2;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ps2_key_source.sv
// PS/2 keyboard receiver: frames bytes off the filtered lines and decodes them into key events.
module ps2_key_source
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 24000000,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ps2_clk_in,
    input  logic             ps2_data_in,
    output logic [KEY_W-1:0] ps2_key,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned     TIMEOUT_CYCLES = TIMEOUT_US * (CLK_HZ / 1000000);
    localparam int unsigned     TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             clk_f;
    logic             data_f;
    logic             clk_f_q;
    logic             fall_c;
    logic             tmo_hit_c;
    ps2_state_t       state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             par_err;
    logic             ext;
    logic             brk;
    logic [2:0]       skip;
    logic [TMO_W-1:0] tmo_cnt;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_in  (ps2_clk_in),
        .line_out (clk_f)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_in  (ps2_data_in),
        .line_out (data_f)
    );

    assign fall_c    = clk_f_q & ~clk_f;
    assign tmo_hit_c = (state != ST_IDLE) && (tmo_cnt == TMO_LAST);

    // Previous filtered clock level for falling-edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) clk_f_q <= 1'b1;
        else          clk_f_q <= clk_f;
    end

    // Cycles since the last filtered falling edge while a frame is in progress
    always_ff @(posedge clk) begin
        if (!reset_n || state == ST_IDLE || fall_c) tmo_cnt <= '0;
        else                                        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // Frame receiver and scancode decoder; a timeout outranks any edge in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            ps2_key   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par_err   <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip      <= '0;
        end else begin
            frame_err <= 1'b0;
            if (tmo_hit_c) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else if (fall_c) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_f) begin
                            state   <= ST_DATA;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                            par_err <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {data_f, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_err <= ~(^{data_f, shift});
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (data_f && !par_err) begin
                            if (skip != 3'd0) begin
                                skip <= skip - 3'd1;
                            end else if (shift == PS2_EXT) begin
                                ext <= 1'b1;
                            end else if (shift == PS2_BRK) begin
                                brk <= 1'b1;
                            end else if (shift == PS2_PAUSE) begin
                                skip <= PAUSE_SKIP;
                            end else begin
                                ps2_key[KEY_TOGGLE_BIT]            <= ~ps2_key[KEY_TOGGLE_BIT];
                                ps2_key[KEY_PRESSED_BIT]           <= ~brk;
                                ps2_key[KEY_EXT_BIT]               <= ext;
                                ps2_key[KEY_CODE_MSB:KEY_CODE_LSB] <= shift;
                                ext <= 1'b0;
                                brk <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                            skip      <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_source.sv
// Randomized and directed bench for ps2_key_source against a frame-level key-event model.
`timescale 1ns/1ps
module tb_ps2_key_source;

    localparam int unsigned CLK_HZ        = 4000000;
    localparam int unsigned TIMEOUT_US    = 200;
    localparam int unsigned FILTER_CYCLES = 8;
    // 250 us of idle line at 4 MHz
    localparam int          IDLE_250US    = 1000;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        ps2_clk_in  = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    ps2_key_source #(
        .CLK_HZ        (CLK_HZ),
        .TIMEOUT_US    (TIMEOUT_US),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #125 clk = ~clk;

    // Frame-level model state
    logic [10:0] m_key;
    bit          m_ext;
    bit          m_brk;
    int          m_skip;
    logic [10:0] exp_q[$];
    int          err_pending;
    int          total;
    int          bad;
    logic [10:0] last_key;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // What one received frame must do to the key stream
    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            err_pending++;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
            m_skip = 0;
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            exp_q.push_back(m_key);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_timeout();
        err_pending++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_reset();
        m_key = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_skip = 0;
        exp_q.delete();
        err_pending = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input bit v, input int h);
        ps2_data_in = v;
        tick(h);
        ps2_clk_in = 1'b0;
        tick(h);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int h);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = ~(^b) ^ bad_par;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) send_bit(bits[i], h);
        ps2_data_in = 1'b1;
        tick(h);
    endtask

    // Every expected event and error must have appeared shortly after the frame
    task automatic drain();
        tick(40);
        check("drain_events", 32'(exp_q.size()), 32'd0);
        check("drain_errors", 32'(err_pending), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        exp_q.delete();
        err_pending = 0;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int h);
        model_frame(b, !bad_par && !bad_stop);
        send_frame(b, bad_par, bad_stop, 11, h);
        drain();
    endtask

    // Every ps2_key change and every frame_err pulse must match the model's next expectation
    always @(negedge clk) begin : compare
        logic [10:0] exp_v;
        if (!reset_n) begin
            last_key = ps2_key;
        end else begin
            if (ps2_key !== last_key) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL key_event got=%0h want=no_change", ps2_key);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (ps2_key !== exp_v) begin
                        bad++;
                        $display("FAIL key_event got=%0h want=%0h", ps2_key, exp_v);
                    end
                end
                last_key = ps2_key;
            end
            if (frame_err !== 1'b0) begin
                total++;
                if (err_pending == 0) begin
                    bad++;
                    $display("FAIL frame_err got=%0b want=0", frame_err);
                end else begin
                    err_pending--;
                end
            end
        end
    end

    initial begin : watchdog
        #50_000_000;
        bad++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] b;
        int         r;
        total = 0;
        bad   = 0;
        model_reset();

        tick(5);
        reset_n = 1'b1;
        tick(2);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // make
        frame(8'h1C, 1'b0, 1'b0, 20);
        check("make", 32'(ps2_key), 32'h61C);

        // break
        frame(8'hF0, 1'b0, 1'b0, 20);
        check("break_prefix_hold", 32'(ps2_key), 32'h61C);
        frame(8'h1C, 1'b0, 1'b0, 20);
        check("break", 32'(ps2_key), 32'h01C);

        // extended, then ext cleared
        frame(8'hE0, 1'b0, 1'b0, 20);
        frame(8'h75, 1'b0, 1'b0, 20);
        check("extended", 32'(ps2_key), 32'h775);
        frame(8'h1C, 1'b0, 1'b0, 20);
        check("ext_cleared", 32'(ps2_key), 32'h21C);

        // parity error, then a clean break sequence
        frame(8'h1C, 1'b1, 1'b0, 20);
        check("parity_err_hold", 32'(ps2_key), 32'h21C);
        frame(8'hF0, 1'b0, 1'b0, 20);
        frame(8'h1C, 1'b0, 1'b0, 20);
        check("brk_after_err", 32'(ps2_key[9:0]), 32'h01C);
        check("brk_after_err_tog", 32'(ps2_key[10]), 32'd1);

        // bad stop bit
        frame(8'h33, 1'b0, 1'b1, 20);
        check("stop_err_hold", 32'(ps2_key), 32'h41C);

        // timeout on a truncated frame
        model_timeout();
        send_frame(8'h1C, 1'b0, 1'b0, 4, 20);
        check("busy_mid_frame", 32'(busy), 32'd1);
        tick(IDLE_250US);
        check("timeout_err", 32'(err_pending), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        frame(8'h1C, 1'b0, 1'b0, 20);
        check("after_timeout", 32'(ps2_key), 32'h21C);

        // short clock glitches with data low must not start a frame
        ps2_data_in = 1'b0;
        tick(20);
        for (int i = 0; i < 5; i++) begin
            ps2_clk_in = 1'b0;
            tick(2);
            ps2_clk_in = 1'b1;
            tick(30);
        end
        check("glitch_busy", 32'(busy), 32'd0);
        ps2_data_in = 1'b1;
        tick(20);
        drain();

        // pause sequence swallowed
        frame(8'hE1, 1'b0, 1'b0, 20);
        frame(8'h14, 1'b0, 1'b0, 20);
        frame(8'h77, 1'b0, 1'b0, 20);
        frame(8'hE1, 1'b0, 1'b0, 20);
        frame(8'hF0, 1'b0, 1'b0, 20);
        frame(8'h14, 1'b0, 1'b0, 20);
        frame(8'hF0, 1'b0, 1'b0, 20);
        frame(8'h77, 1'b0, 1'b0, 20);
        check("pause_swallowed", 32'(ps2_key), 32'h21C);
        frame(8'h1C, 1'b0, 1'b0, 20);
        check("after_pause", 32'(ps2_key), 32'h61C);

        // reset mid-frame
        send_frame(8'h5A, 1'b0, 1'b0, 5, 20);
        reset_n = 1'b0;
        tick(3);
        model_reset();
        reset_n = 1'b1;
        tick(2);
        check("midreset_key", 32'(ps2_key), 32'h000);
        check("midreset_busy", 32'(busy), 32'd0);
        tick(IDLE_250US);
        drain();
        frame(8'h1C, 1'b0, 1'b0, 20);
        check("after_midreset", 32'(ps2_key), 32'h61C);

        // randomized traffic including prefixes, pause and corrupted frames
        for (int n = 0; n < 50; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = (($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h12);
                default: b = 8'($urandom_range(0, 255));
            endcase
            frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                  int'($urandom_range(12, 30)));
            check("rand_key", 32'(ps2_key), 32'(m_key));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_source.md
PS2_KEY_SOURCE -- requirements
Module: ps2_key_source

Interface
REQ-001 SHALL have parameter CLK_HZ, default 24000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 200, meaning the maximum gap between falling edges inside one frame, in microseconds.
REQ-003 SHALL have parameter FILTER_CYCLES, default 8, meaning the number of consecutive stable samples needed before a line level is accepted.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for the whole block.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, synchronous to clk and active-low.
REQ-006 SHALL have port ps2_clk_in, input, 1 bit: raw asynchronous PS/2 clock line, idle high.
REQ-007 SHALL have port ps2_data_in, input, 1 bit: raw asynchronous PS/2 data line, idle high.
REQ-008 SHALL have port ps2_key, output, 11 bits: key event word. Bit [10] is a toggle strobe, bit [9] is pressed, bit [8] is extended, bits [7:0] are the scancode.
REQ-009 SHALL have port frame_err, output, 1 bit: a one-cycle pulse when a frame is discarded.
REQ-010 SHALL have port busy, output, 1 bit: high while the receiver is not in IDLE.

Function
REQ-011 SHALL pass each line through a 2-flop synchronizer, then a stability filter. The filtered level changes only after FILTER_CYCLES identical synchronized samples.
REQ-012 SHALL act only on falling edges of the filtered clock line, sampling the filtered data line in the same cycle.
REQ-013 SHALL run the FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, one edge per step.
- IDLE: an edge with data 0 (start bit) moves to DATA; an edge with data 1 is ignored.
- DATA: shift in 8 bits LSB first, counted by a 3-bit counter, then go to PARITY.
REQ-014 SHALL check odd parity over the 8 data bits plus the parity bit. A mismatch sets a parity-error flag, which is evaluated at STOP.
REQ-015 SHALL, at STOP, treat data 1 with no parity error as a valid byte. Any other case SHALL pulse frame_err, discard the byte, clear all prefix flags and skip count, and return to IDLE.
REQ-016 SHALL apply a timeout in any state other than IDLE. When TIMEOUT_US*(CLK_HZ/1000000) clocks pass with no filtered falling edge, it SHALL pulse frame_err, clear prefix flags, and return to IDLE.
REQ-017 SHALL decode valid bytes as follows:
- 0xE0 sets the ext flag.
- 0xF0 sets the brk flag.
- 0xE1 loads skip count 7.
- Any byte received while skip count > 0 decrements the count and is not emitted.
REQ-018 SHALL handle any other valid byte by updating ps2_key to {~ps2_key[10], ~brk, ext, byte} in the cycle after the STOP edge, then clearing ext and brk.
REQ-019 SHALL hold ps2_key constant between events; only the toggle indicates a new event.
REQ-020 SHALL give a timeout or a frame_err in the same cycle as a STOP edge priority over byte acceptance. At most one frame_err pulse SHALL be produced per frame.
REQ-021 SHALL restart the timeout count on every filtered falling edge. The count SHALL be sized to hold the full timeout value with no wrap.

Reset
REQ-022 SHALL, while reset_n is 0 at a clk edge, set the following:
- state to IDLE;
- ps2_key to 11'h000;
- frame_err and busy to 0;
- ext, brk, skip count, bit counter and timeout counter to 0;
- synchronizer and filter outputs to 1.
REQ-023 SHALL, on reset mid-frame, discard the partial frame without pulsing frame_err. The next start bit after release SHALL be received normally.

Structure
REQ-024 SHALL take the following from the shared package ps2_pkg:
- the FSM state enum;
- byte constants PS2_EXT (0xE0), PS2_BRK (0xF0) and PS2_PAUSE (0xE1);
- PAUSE_SKIP (7);
- the ps2_key field bit positions.
REQ-025 SHALL contain sub-module ps2_line_filter (synchronizer plus stability filter, parameter FILTER_CYCLES), instantiated once for the clock line and once for the data line.

Verification
REQ-026 SHALL test make: after reset, a valid frame 0x1C -> ps2_key = 11'h61C exactly once, frame_err stays 0.
REQ-027 SHALL test break: after REQ-026, frames F0,1C -> ps2_key = 11'h01C, with only one update (after the 1C frame).
REQ-028 SHALL test extended: frames E0,75 -> ps2_key = 11'h775; a following frame 0x1C -> 11'h21C (ext cleared).
REQ-029 SHALL test errors:
- frame 0x1C with even parity -> one frame_err pulse, ps2_key unchanged;
- a following F0,1C -> 11'h01C (brk not corrupted).
REQ-030 SHALL test timeout and glitches:
- 4 bits sent, then lines idle for 250 us -> frame_err pulse, busy 0, next frame 0x1C accepted;
- 2-cycle glitches on ps2_clk_in produce no edge.
REQ-031 SHALL test pause and reset:
- E1,14,77,E1,F0,14,F0,77 then 0x1C -> only the 0x1C event is emitted;
- reset_n low mid-frame -> ps2_key 11'h000, no frame_err, next frame received.
